// File: rtl/id_ex_stage_pkg.sv
// Shared opcode constants, ALUOp encodings and the control bundle carried ID -> EX.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // Only these opcodes actually read the Rt register.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detection and WB->ID bypass request for the ID/EX stage.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [5:0]        opcode_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              mem_read_ex_i,
  input  logic [REG_AW-1:0] rt_ex_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic              wb_we_i,
  output logic              stall_o,
  output logic [1:0]        fwd_o
);

  logic uses_rt;
  logic hazard;
  logic wb_valid;

  always_comb begin
    uses_rt  = op_uses_rt(opcode_i);
    hazard   = mem_read_ex_i && (rt_ex_i != '0) &&
               ((rt_ex_i == rs_i) || ((rt_ex_i == rt_i) && uses_rt));
    // A flushed instruction is discarded anyway, so it never needs to wait.
    stall_o  = hazard && !flush_i;
    wb_valid = wb_we_i && (wb_reg_i != '0);
    fwd_o    = {wb_valid && (wb_reg_i == rt_i), wb_valid && (wb_reg_i == rs_i)};
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instruction_ID,
  input  logic [DATA_W-1:0] PC_Plus_4_ID,
  input  logic [DATA_W-1:0] Read_Data_1_ID,
  input  logic [DATA_W-1:0] Read_Data_2_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              MemtoReg_ID,
  input  logic              ALUSrc_ID,
  input  logic              RegDst_ID,
  input  logic [1:0]        ALUOp_ID,
  input  logic              Flush_ID,
  input  logic [REG_AW-1:0] Write_Register_WB,
  input  logic              RegWrite_WB,
  output logic [1:0]        Forward_Reg_Delay,
  output logic              Stall_IF_ID,
  output logic              RegWrite_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              MemtoReg_EX,
  output logic              ALUSrc_EX,
  output logic              RegDst_EX,
  output logic [1:0]        ALUOp_EX,
  output logic [DATA_W-1:0] Read_Data_1_EX,
  output logic [DATA_W-1:0] Read_Data_2_EX,
  output logic [DATA_W-1:0] PC_Plus_4_EX,
  output logic [DATA_W-1:0] Imm_EX,
  output logic [REG_AW-1:0] Rs_EX,
  output logic [REG_AW-1:0] Rt_EX,
  output logic [REG_AW-1:0] Rd_EX,
  output logic [CNT_W-1:0]  Stall_Count
);

  logic [REG_AW-1:0] rs_id, rt_id, rd_id;
  logic [DATA_W-1:0] imm_id;
  ctrl_t             ctrl_id;

  ctrl_t             ctrl_d, ctrl_q;
  logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, pc4_d, pc4_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              stall;

  always_comb begin
    rs_id   = REG_AW'(Instruction_ID[25:21]);
    rt_id   = REG_AW'(Instruction_ID[20:16]);
    rd_id   = REG_AW'(Instruction_ID[15:11]);
    imm_id  = {{(DATA_W-16){Instruction_ID[15]}}, Instruction_ID[15:0]};
    ctrl_id = '{reg_write:  RegWrite_ID,
                mem_read:   MemRead_ID,
                mem_write:  MemWrite_ID,
                mem_to_reg: MemtoReg_ID,
                alu_src:    ALUSrc_ID,
                reg_dst:    RegDst_ID,
                alu_op:     ALUOp_ID};
  end

  id_ex_stage_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .opcode_i      (Instruction_ID[31:26]),
    .rs_i          (rs_id),
    .rt_i          (rt_id),
    .mem_read_ex_i (ctrl_q.mem_read),
    .rt_ex_i       (rt_q),
    .flush_i       (Flush_ID),
    .wb_reg_i      (Write_Register_WB),
    .wb_we_i       (RegWrite_WB),
    .stall_o       (stall),
    .fwd_o         (Forward_Reg_Delay)
  );

  always_comb begin
    // Data and fields load even on a bubble; only the control is squashed.
    ctrl_d = (Flush_ID || stall) ? '0 : ctrl_id;
    rd1_d  = Read_Data_1_ID;
    rd2_d  = Read_Data_2_ID;
    pc4_d  = PC_Plus_4_ID;
    imm_d  = imm_id;
    rs_d   = rs_id;
    rt_d   = rt_id;
    rd_d   = rd_id;
    cnt_d  = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      pc4_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      pc4_q  <= pc4_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Stall_IF_ID    = stall;
  assign RegWrite_EX    = ctrl_q.reg_write;
  assign MemRead_EX     = ctrl_q.mem_read;
  assign MemWrite_EX    = ctrl_q.mem_write;
  assign MemtoReg_EX    = ctrl_q.mem_to_reg;
  assign ALUSrc_EX      = ctrl_q.alu_src;
  assign RegDst_EX      = ctrl_q.reg_dst;
  assign ALUOp_EX       = ctrl_q.alu_op;
  assign Read_Data_1_EX = rd1_q;
  assign Read_Data_2_EX = rd2_q;
  assign PC_Plus_4_EX   = pc4_q;
  assign Imm_EX         = imm_q;
  assign Rs_EX          = rs_q;
  assign Rt_EX          = rt_q;
  assign Rd_EX          = rd_q;
  assign Stall_Count    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a narrow-counter second instance covers saturation.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instruction_ID, PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID;
  logic        RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, RegDst_ID;
  logic [1:0]  ALUOp_ID;
  logic        Flush_ID;
  logic [4:0]  Write_Register_WB;
  logic        RegWrite_WB;

  logic [1:0]  Forward_Reg_Delay;
  logic        Stall_IF_ID;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, RegDst_EX;
  logic [1:0]  ALUOp_EX;
  logic [31:0] Read_Data_1_EX, Read_Data_2_EX, PC_Plus_4_EX, Imm_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic [15:0] Stall_Count;

  logic [1:0]  s_fwd;
  logic        s_stall, s_rw, s_mr, s_mw, s_m2r, s_as, s_rd;
  logic [1:0]  s_aop;
  logic [31:0] s_d1, s_d2, s_pc, s_imm;
  logic [4:0]  s_rs, s_rt, s_rdx;
  logic [7:0]  s_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 Clk = ~Clk;

  id_ex_stage u_dut (
    .Clk(Clk), .Reset(Reset), .Instruction_ID(Instruction_ID), .PC_Plus_4_ID(PC_Plus_4_ID),
    .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID),
    .ALUOp_ID(ALUOp_ID), .Flush_ID(Flush_ID), .Write_Register_WB(Write_Register_WB),
    .RegWrite_WB(RegWrite_WB), .Forward_Reg_Delay(Forward_Reg_Delay),
    .Stall_IF_ID(Stall_IF_ID), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX),
    .RegDst_EX(RegDst_EX), .ALUOp_EX(ALUOp_EX), .Read_Data_1_EX(Read_Data_1_EX),
    .Read_Data_2_EX(Read_Data_2_EX), .PC_Plus_4_EX(PC_Plus_4_EX), .Imm_EX(Imm_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX), .Stall_Count(Stall_Count)
  );

  id_ex_stage #(.CNT_W(8)) u_dut_sat (
    .Clk(Clk), .Reset(Reset), .Instruction_ID(Instruction_ID), .PC_Plus_4_ID(PC_Plus_4_ID),
    .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID),
    .ALUOp_ID(ALUOp_ID), .Flush_ID(Flush_ID), .Write_Register_WB(Write_Register_WB),
    .RegWrite_WB(RegWrite_WB), .Forward_Reg_Delay(s_fwd), .Stall_IF_ID(s_stall),
    .RegWrite_EX(s_rw), .MemRead_EX(s_mr), .MemWrite_EX(s_mw), .MemtoReg_EX(s_m2r),
    .ALUSrc_EX(s_as), .RegDst_EX(s_rd), .ALUOp_EX(s_aop), .Read_Data_1_EX(s_d1),
    .Read_Data_2_EX(s_d2), .PC_Plus_4_EX(s_pc), .Imm_EX(s_imm), .Rs_EX(s_rs), .Rt_EX(s_rt),
    .Rd_EX(s_rdx), .Stall_Count(s_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Sets instruction and control bundle {rw, mr, mw, m2r, as, rd, aop[1:0]}.
  task automatic set_id(input logic [31:0] instr, input logic [7:0] ctrl);
    Instruction_ID = instr;
    {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID} = ctrl;
    #1;
  endtask

  function automatic logic [7:0] ex_ctrl();
    return {RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, RegDst_EX, ALUOp_EX};
  endfunction

  localparam logic [7:0] CTRL_LW  = 8'b1101_1000;
  localparam logic [7:0] CTRL_ADD = 8'b1000_0110;

  initial begin
    // Reset with random inputs
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      Instruction_ID = $urandom; PC_Plus_4_ID = $urandom;
      Read_Data_1_ID = $urandom; Read_Data_2_ID = $urandom;
      {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID} =
        8'($urandom);
      Flush_ID = 1'($urandom); Write_Register_WB = 5'($urandom); RegWrite_WB = 1'($urandom);
      tick();
    end
    check_eq("reset_ctrl", 32'(ex_ctrl()), 32'h0);
    check_eq("reset_rd1", Read_Data_1_EX, 32'h0);
    check_eq("reset_imm", Imm_EX, 32'h0);
    check_eq("reset_rt", 32'(Rt_EX), 32'h0);
    check_eq("reset_cnt", 32'(Stall_Count), 32'h0);
    check_eq("reset_stall", 32'(Stall_IF_ID), 32'h0);

    Reset = 1'b0; Flush_ID = 1'b0; RegWrite_WB = 1'b0; Write_Register_WB = 5'd0;

    // Pass-through: add $3,$1,$2
    Read_Data_1_ID = 32'd5; Read_Data_2_ID = 32'd7; PC_Plus_4_ID = 32'h104;
    set_id(32'h0022_1820, CTRL_ADD);
    tick();
    check_eq("pt_rd1", Read_Data_1_EX, 32'd5);
    check_eq("pt_rd2", Read_Data_2_EX, 32'd7);
    check_eq("pt_rd", 32'(Rd_EX), 32'd3);
    check_eq("pt_rs", 32'(Rs_EX), 32'd1);
    check_eq("pt_rt", 32'(Rt_EX), 32'd2);
    check_eq("pt_imm", Imm_EX, 32'h0000_1820);
    check_eq("pt_pc4", PC_Plus_4_EX, 32'h104);
    check_eq("pt_ctrl", 32'(ex_ctrl()), 32'(CTRL_ADD));
    check_eq("pt_stall", 32'(Stall_IF_ID), 32'h0);

    // Sign extension of a negative immediate: lw $8,-4($1)
    set_id(32'h8C28_FFFC, CTRL_LW);
    tick();
    check_eq("imm_neg", Imm_EX, 32'hFFFF_FFFC);

    // Load-use: lw $8 in EX, add $9,$8,$1 in ID
    set_id(32'h0101_4820, CTRL_ADD);
    check_eq("lu_stall", 32'(Stall_IF_ID), 32'h1);
    tick();
    exp_cnt++;
    check_eq("lu_bubble", 32'(ex_ctrl()), 32'h0);
    check_eq("lu_cnt", 32'(Stall_Count), 32'(exp_cnt));
    check_eq("lu_stall_drop", 32'(Stall_IF_ID), 32'h0);
    tick();
    check_eq("lu_pass_ctrl", 32'(ex_ctrl()), 32'(CTRL_ADD));
    check_eq("lu_pass_rd", 32'(Rd_EX), 32'd9);
    check_eq("lu_pass_rs", 32'(Rs_EX), 32'd8);
    check_eq("lu_pass_cnt", 32'(Stall_Count), 32'(exp_cnt));

    // No false stall: lw $0 then add $9,$0,$0
    set_id(32'h8C20_0000, CTRL_LW);
    tick();
    set_id(32'h0000_4820, CTRL_ADD);
    check_eq("nfs_r0", 32'(Stall_IF_ID), 32'h0);

    // lw $9 then addi $9,$2,4 (rt not read) vs sw $9,0($2) (rt read)
    set_id(32'h8C29_0000, CTRL_LW);
    tick();
    set_id(32'h2049_0004, 8'b1000_1000);
    check_eq("nfs_addi", 32'(Stall_IF_ID), 32'h0);
    set_id(32'hAC49_0000, 8'b0010_1000);
    check_eq("sw_rt_stall", 32'(Stall_IF_ID), 32'h1);

    // Bypass requests (EX still holds lw $9; these IDs do not touch $9)
    set_id(32'h00A5_0820, CTRL_ADD);
    RegWrite_WB = 1'b1; Write_Register_WB = 5'd5; #1;
    check_eq("fwd_both", 32'(Forward_Reg_Delay), 32'h3);
    Write_Register_WB = 5'd0; #1;
    check_eq("fwd_r0", 32'(Forward_Reg_Delay), 32'h0);
    Write_Register_WB = 5'd5; RegWrite_WB = 1'b0; #1;
    check_eq("fwd_no_we", 32'(Forward_Reg_Delay), 32'h0);
    set_id(32'h00A6_0820, CTRL_ADD);
    RegWrite_WB = 1'b1; #1;
    check_eq("fwd_rs", 32'(Forward_Reg_Delay), 32'h1);
    Write_Register_WB = 5'd6; #1;
    check_eq("fwd_rt", 32'(Forward_Reg_Delay), 32'h2);
    RegWrite_WB = 1'b0; Write_Register_WB = 5'd0;

    // Flush wins over a load-use hazard
    set_id(32'h8C28_0000, CTRL_LW);
    tick();
    set_id(32'h0101_4820, CTRL_ADD);
    Flush_ID = 1'b1; #1;
    check_eq("flush_stall", 32'(Stall_IF_ID), 32'h0);
    tick();
    Flush_ID = 1'b0;
    check_eq("flush_bubble", 32'(ex_ctrl()), 32'h0);
    check_eq("flush_cnt", 32'(Stall_Count), 32'(exp_cnt));

    // Saturation: lw $8,0($8) repeatedly stalls on itself every other cycle
    set_id(32'h8D08_0000, CTRL_LW);
    for (int i = 0; i < 600; i++) tick();
    exp_cnt += 300;
    check_eq("cnt_main", 32'(Stall_Count), 32'(exp_cnt));
    check_eq("cnt_sat", 32'(s_cnt), 32'hFF);

    // Reset while a stall is pending
    tick();
    check_eq("mid_stall", 32'(Stall_IF_ID), 32'h1);
    Reset = 1'b1;
    tick();
    check_eq("rst_mid_cnt", 32'(Stall_Count), 32'h0);
    check_eq("rst_mid_mr", 32'(MemRead_EX), 32'h0);
    check_eq("rst_mid_stall", 32'(Stall_IF_ID), 32'h0);
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
